// File: rtl/addsub_seq_if.sv
// Request/result handshake bundle for the byte-serial add/sub controller.
// The requester/consumer side uses master; the controller uses slave.
interface addsub_seq_if #(
   parameter int NBYTES = 4
) ();
   localparam int W = 8 * NBYTES;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         M;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] S;
   logic         C;
   logic         V;
   logic         N;
   logic         Z;

   modport master (
      output in_valid, A, B, M, out_ready,
      input  in_ready, out_valid, S, C, V, N, Z
   );

   modport slave (
      input  in_valid, A, B, M, out_ready,
      output in_ready, out_valid, S, C, V, N, Z
   );
endinterface

// File: rtl/addsub_seq.sv
// Multi-precision add/subtract built from one 8-bit slice reused over
// NBYTES cycles, least significant byte first, with a registered carry chain.
module addsub_seq #(
   parameter int NBYTES = 4,
   parameter int CW     = 3
) (
   input  logic         clk,
   input  logic         rst,
   addsub_seq_if.slave  bus,
   output logic         busy
);
   localparam int W = 8 * NBYTES;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           idx_q, idx_d;
   logic [NBYTES-1:0][7:0]  a_q, a_d;
   logic [NBYTES-1:0][7:0]  b_q, b_d;
   logic [NBYTES-1:0][7:0]  s_q, s_d;
   logic                    m_q, m_d;
   logic                    carry_q, carry_d;
   logic                    zacc_q, zacc_d;
   logic                    c_q, c_d;
   logic                    v_q, v_d;
   logic                    n_q, n_d;
   logic                    z_q, z_d;
   logic                    out_valid_q, out_valid_d;
   logic                    in_ready_q, in_ready_d;
   logic                    busy_q, busy_d;

   logic [7:0] a_k, b_raw, b_k;
   logic       cin, last, zbyte;
   logic [8:0] sum9;

   // One 8-bit slice: {cout, s} = a + b + cin
   function automatic logic [8:0] add_slice(input logic [7:0] a, input logic [7:0] b,
                                            input logic cin_i);
      return {1'b0, a} + {1'b0, b} + {8'd0, cin_i};
   endfunction

   always_comb begin
      a_k   = '0;
      b_raw = '0;
      for (int k = 0; k < NBYTES; k++) begin
         if (idx_q == CW'(k)) begin
            a_k   = a_q[k];
            b_raw = b_q[k];
         end
      end
      b_k   = m_q ? ~b_raw : b_raw;
      cin   = (idx_q == '0) ? m_q : carry_q;
      sum9  = add_slice(a_k, b_k, cin);
      zbyte = (sum9[7:0] == 8'd0);
      last  = (idx_q == CW'(NBYTES - 1));

      state_d     = state_q;
      idx_d       = idx_q;
      a_d         = a_q;
      b_d         = b_q;
      s_d         = s_q;
      m_d         = m_q;
      carry_d     = carry_q;
      zacc_d      = zacc_q;
      c_d         = c_q;
      v_d         = v_q;
      n_d         = n_q;
      z_d         = z_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;
      busy_d      = busy_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d        = bus.A;
               b_d        = bus.B;
               m_d        = bus.M;
               idx_d      = '0;
               state_d    = BUSY;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         BUSY: begin
            for (int k = 0; k < NBYTES; k++) begin
               if (idx_q == CW'(k)) s_d[k] = sum9[7:0];
            end
            carry_d = sum9[8];
            zacc_d  = (idx_q == '0) ? zbyte : (zacc_q & zbyte);
            idx_d   = idx_q + 1'b1;
            // Top byte: its operand/result MSBs are the W-bit sign bits
            if (last) begin
               c_d         = sum9[8];
               n_d         = sum9[7];
               v_d         = (~sum9[7] & a_k[7] & b_k[7]) | (sum9[7] & ~a_k[7] & ~b_k[7]);
               z_d         = zacc_d;
               idx_d       = '0;
               state_d     = DONE;
               out_valid_d = 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               busy_d      = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         s_q         <= '0;
         m_q         <= 1'b0;
         carry_q     <= 1'b0;
         zacc_q      <= 1'b0;
         c_q         <= 1'b0;
         v_q         <= 1'b0;
         n_q         <= 1'b0;
         z_q         <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         a_q         <= a_d;
         b_q         <= b_d;
         s_q         <= s_d;
         m_q         <= m_d;
         carry_q     <= carry_d;
         zacc_q      <= zacc_d;
         c_q         <= c_d;
         v_q         <= v_d;
         n_q         <= n_d;
         z_q         <= z_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.S         = s_q;
   assign bus.C         = c_q;
   assign bus.V         = v_q;
   assign bus.N         = n_q;
   assign bus.Z         = z_q;
   assign bus.out_valid = out_valid_q;
   assign bus.in_ready  = in_ready_q;
   assign busy          = busy_q;
endmodule

// File: tb/tb_addsub_seq.sv
// Directed and randomised bench for addsub_seq (NBYTES=4, W=32).
module tb_addsub_seq;
   localparam int NBYTES = 4;
   localparam int W      = 8 * NBYTES;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   int   n_checks = 0;
   int   n_err    = 0;

   addsub_seq_if #(.NBYTES(NBYTES)) bus ();

   addsub_seq #(.NBYTES(NBYTES), .CW(3)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus.slave),
      .busy (busy)
   );

   always #5 clk = ~clk;

   logic [35:0] res;
   assign res = {bus.S, bus.C, bus.V, bus.N, bus.Z};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: {C,S} = A + (M ? ~B : B) + M, flags from the W-bit MSBs
   function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic m);
      logic [31:0] bb;
      logic [32:0] sum;
      logic        v;
      bb  = m ? ~b : b;
      sum = {1'b0, a} + {1'b0, bb} + {32'd0, m};
      v   = (~sum[31] & a[31] & bb[31]) | (sum[31] & ~a[31] & ~bb[31]);
      return {sum[31:0], sum[32], v, sum[31], (sum[31:0] == 32'd0)};
   endfunction

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic m);
      bus.A        = a;
      bus.B        = b;
      bus.M        = m;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      bus.A        = ~a;
      bus.B        = ~b;
      bus.M        = ~m;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
         step();
         lat++;
      end
   endtask

   task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic m, input logic [35:0] exp);
      int lat;
      chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
      send(a, b, m);
      wait_out(lat);
      chk({tag, "_latency"}, 64'(lat), 64'(4));
      chk({tag, "_result"}, 64'(res), 64'(exp));
      chk({tag, "_busy"}, 64'(busy), 64'(1));
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk({tag, "_ovalid_drop"}, 64'(bus.out_valid), 64'(0));
      chk({tag, "_in_ready_back"}, 64'(bus.in_ready), 64'(1));
      chk({tag, "_result_kept"}, 64'(res), 64'(exp));
   endtask

   initial begin
      int          lat;
      logic        seen;
      logic [31:0] ra, rb;
      logic        rm;
      logic [35:0] rexp;

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.A         = '0;
      bus.B         = '0;
      bus.M         = 1'b0;
      rst           = 1'b1;
      step();
      step();
      rst = 1'b0;

      chk("rst_result", 64'(res), 64'(0));
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
      chk("rst_busy", 64'(busy), 64'(0));

      // S, C, V, N, Z
      directed("add_ovf",  32'h7FFFFFFF, 32'h00000001, 1'b0, {32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0});
      directed("add_cry",  32'hFFFFFFFF, 32'h00000001, 1'b0, {32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1});
      directed("sub_brw",  32'h00000000, 32'h00000001, 1'b1, {32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0});
      directed("sub_eq",   32'h12345678, 32'h12345678, 1'b1, {32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1});
      directed("sub_sovf", 32'h80000000, 32'h00000001, 1'b1, {32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0});

      // Backpressure with a stray request during the hold window
      send(32'h000000FF, 32'h00000001, 1'b0);
      wait_out(lat);
      chk("bp_latency", 64'(lat), 64'(4));
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            bus.A        = 32'h00001234;
            bus.B        = 32'h00000001;
            bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         step();
         chk("bp_result", 64'(res), 64'({32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0}));
         chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
         chk("bp_busy", 64'(busy), 64'(1));
         chk("bp_out_valid", 64'(bus.out_valid), 64'(1));
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk("bp_hs_out_valid", 64'(bus.out_valid), 64'(0));
      chk("bp_hs_in_ready", 64'(bus.in_ready), 64'(1));
      chk("bp_hs_busy", 64'(busy), 64'(0));
      step();
      chk("bp_no_accept_busy", 64'(busy), 64'(0));
      chk("bp_no_accept_ovalid", 64'(bus.out_valid), 64'(0));

      // Reset at E2 of an operation
      send(32'hFFFFFFFF, 32'h00000001, 1'b0);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_result", 64'(res), 64'(0));
      chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
      chk("mid_rst_busy", 64'(busy), 64'(0));
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (bus.out_valid === 1'b1) seen = 1'b1;
      end
      chk("mid_rst_no_out_valid", 64'(seen), 64'(0));
      directed("after_rst", 32'h01020304, 32'h10203040, 1'b0, {32'h11223344, 1'b0, 1'b0, 1'b0, 1'b0});

      // Back-to-back random operations with random consumer stalls
      for (int i = 0; i < 400; i++) begin
         ra   = $urandom;
         rb   = $urandom;
         rm   = 1'($urandom_range(0, 1));
         rexp = model(ra, rb, rm);
         send(ra, rb, rm);
         wait_out(lat);
         chk("rand_latency", 64'(lat), 64'(4));
         repeat ($urandom_range(0, 3)) step();
         chk("rand_result", 64'(res), 64'(rexp));
         bus.out_ready = 1'b1;
         step();
         bus.out_ready = 1'(($urandom_range(0, 1)));
      end
      bus.out_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
